// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   NOP_WORD     : word returned on a faulting fetch and after reset (addi x0,x0,0)
//   imem_state_e : LOAD / RUN phase encoding
//   word_addr_ok : aligned, fully in-range word check used by both load and fetch paths
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // True when a 4-byte word at addr lies entirely inside a store of depth_bytes.
  // Addresses are zero-extended to 64 bits, so any set upper bit fails the
  // compare and nothing ever wraps. depth_bytes >= 8, so the subtraction is safe.
  function automatic logic word_addr_ok(input logic [63:0] addr,
                                        input logic [63:0] depth_bytes);
    return (addr[1:0] == 2'b00) && (addr <= depth_bytes - 64'd4);
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-organised program store.
//   clk   : write clock
//   we    : write one 32-bit word at word index waddr
//   waddr : word index of the write
//   wdata : write data, bits [7:0] land at the lowest byte address
//   raddr : word index of the asynchronous read
//   rdata : little-endian word read at raddr
// Contents are deliberately not reset so a program survives a core reset.
module imem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 256,
  localparam int unsigned WORD_W     = $clog2(DEPTH_BYTES) - 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{waddr, 2'd0}] <= wdata[7:0];
      mem[{waddr, 2'd1}] <= wdata[15:8];
      mem[{waddr, 2'd2}] <= wdata[23:16];
      mem[{waddr, 2'd3}] <= wdata[31:24];
    end
  end

  always_comb begin
    rdata = {mem[{raddr, 2'd3}], mem[{raddr, 2'd2}], mem[{raddr, 2'd1}], mem[{raddr, 2'd0}]};
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the RISC-V datapath.
// The store is written word-by-word in the LOAD phase; load_done switches to the
// RUN phase, where registered 1-cycle fetches are served with stall support and
// misaligned / out-of-range fetches are flagged instead of returning garbage.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   load_en/addr/data     : word write (LOAD only)
//   load_done             : pulse, LOAD -> RUN
//   fetch_req/addr/stall  : fetch request (RUN only), stall freezes fetch outputs
//   instruction           : registered fetched word
//   fetch_valid/fault     : response valid / response faulted
//   load_err              : sticky, a load write was dropped
//   run_mode              : 1 in RUN
//   load_count            : accepted load writes, saturating at DEPTH_BYTES/4
// ADDR_W must not exceed 64.
module imem_loadable #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD,
  localparam int unsigned CNT_W      = $clog2(DEPTH_BYTES / 4) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [31:0]       instruction,
  output logic              fetch_valid,
  output logic              fetch_fault,
  output logic              load_err,
  output logic              run_mode,
  output logic [CNT_W-1:0]  load_count
);

  import imem_pkg::*;

  localparam int unsigned IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [63:0] DEPTH64   = 64'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH_BYTES / 4);

  imem_state_e state_q, state_d;

  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             load_err_q, load_err_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;

  logic [63:0] load_addr_ext, fetch_addr_ext;
  logic        load_ok, fetch_ok, mem_we, fetch_accept;
  logic [31:0] mem_rdata;

  imem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_byte_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr[IDX_W-1:2]),
    .wdata(load_data),
    .raddr(fetch_addr[IDX_W-1:2]),
    .rdata(mem_rdata)
  );

  // Zero-extend so the range check sees every upper address bit.
  always_comb begin
    load_addr_ext                 = '0;
    load_addr_ext[ADDR_W-1:0]     = load_addr;
    fetch_addr_ext                = '0;
    fetch_addr_ext[ADDR_W-1:0]    = fetch_addr;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. RUN is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (load_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_mode = (state_q == ST_RUN);
  end

  // Load path and fetch response next-state.
  always_comb begin
    load_ok  = word_addr_ok(load_addr_ext, DEPTH64);
    fetch_ok = word_addr_ok(fetch_addr_ext, DEPTH64);

    mem_we     = load_en && load_ok && (state_q == ST_LOAD);
    load_err_d = load_err_q | (load_en & ~mem_we);

    load_count_d = load_count_q;
    if (mem_we && (load_count_q != CNT_MAX)) begin
      load_count_d = load_count_q + CNT_W'(1);
    end

    fetch_accept = (state_q == ST_RUN) && fetch_req && !fetch_stall;

    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (!fetch_stall) begin
      valid_d = fetch_accept;
      fault_d = fetch_accept && !fetch_ok;
      if (fetch_accept) begin
        instr_d = fetch_ok ? mem_rdata : NOP_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q      <= NOP_WORD;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      load_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      load_err_q   <= load_err_d;
      load_count_q <= load_count_d;
    end
  end

  assign instruction = instr_q;
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;
  assign load_err    = load_err_q;
  assign load_count  = load_count_q;

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised successor to the fixed-content instruction memory for the RISC-V datapath. It holds a byte-addressed, little-endian program store that is written word-by-word over a load port. The store is filled while the core is held in a LOAD phase. It then serves registered, stall-aware instruction fetches in a RUN phase, and flags misaligned or out-of-range fetches instead of returning garbage.

Parameters:
ADDR_W, 64, width of fetch_addr/load_addr (matches 64-bit PC).
DEPTH_BYTES, 256, store size in bytes; power of 2, multiple of 4, at least 8.
NOP_WORD, 32'h00000013, word returned on faulting fetch and after reset (addi x0,x0,0).

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
load_en  in  1  write one word this cycle (honoured only in LOAD).
load_addr  in  ADDR_W  byte address of word to write.
load_data  in  32  word to write; bits [7:0] go to the lowest address.
load_done  in  1  single-cycle pulse; ends LOAD, enters RUN.
fetch_req  in  1  fetch request (honoured only in RUN).
fetch_addr  in  ADDR_W  byte address of instruction (PC).
fetch_stall  in  1  hold all fetch outputs and ignore fetch_req.
instruction  out  32  registered fetched word.
fetch_valid  out  1  instruction is the response to a request accepted last cycle.
fetch_fault  out  1  accompanying fetch was misaligned or out of range.
load_err  out  1  sticky; a load write was dropped.
run_mode  out  1  1 in RUN, 0 in LOAD.
load_count  out  $clog2(DEPTH_BYTES/4)+1  accepted load writes, saturating at DEPTH_BYTES/4.

Behaviour:
- Reset values: state LOAD, run_mode 0, instruction NOP_WORD, fetch_valid 0, fetch_fault 0, load_err 0, load_count 0. Store contents are NOT cleared by reset.
- FSM LOAD:
  - load_en with load_addr[1:0]==0 and load_addr+3 < DEPTH_BYTES: write the 4 bytes little-endian at load_addr..load_addr+3; load_count +1 (saturating).
  - Otherwise, load_en drops the write and sets load_err.
  - fetch_req is ignored; fetch_valid stays 0.
  - load_done moves to RUN next cycle. If load_en and load_done arrive in the same cycle, the write is performed first, then the transition happens.
- FSM RUN:
  - load_en is ignored and sets load_err.
  - load_done is ignored.
  - RUN exits only via reset.
- Fetch (RUN only), latency 1 cycle:
  - If fetch_stall=0 and fetch_req=1, the request is accepted. Next cycle fetch_valid=1 and instruction={mem[a+3],mem[a+2],mem[a+1],mem[a]}.
  - Fault condition: a[1:0]!=0, or a+3 >= DEPTH_BYTES, or any upper address bit beyond the store set. On a fault the next cycle gives instruction=NOP_WORD, fetch_fault=1, fetch_valid=1. Never wrap the address.
  - fetch_stall=1: instruction, fetch_valid and fetch_fault hold their values; fetch_req is ignored that cycle.
  - fetch_stall=0 and fetch_req=0: next cycle fetch_valid=0 and fetch_fault=0; instruction holds its last value.
- Back-to-back accepted requests produce one response per cycle.
- Reset mid-RUN or mid-LOAD: state returns to LOAD and all outputs return to reset values; previously loaded words are retained and can be fetched after a new load_done.
- Reset has priority over load_en, load_done and fetch_req in the same cycle.

Decomposition:
- Shared package/header imem_pkg:
  - NOP_WORD constant.
  - State encoding ST_LOAD/ST_RUN.
  - Helper for the aligned/in-range check, shared by the load and fetch paths.
- One sub-module imem_byte_array: byte array of DEPTH_BYTES with a 32-bit little-endian word write port and an asynchronous word read port. The top owns the FSM, checks, counters and output registers.

Test Plan:
- Load 0x01900293 at address 0, pulse load_done, fetch_req at 0 -> next cycle instruction=0x01900293, fetch_valid=1, fetch_fault=0, load_count=1.
- In RUN, fetch 0x2 and then 0x100 (DEPTH 256) -> each response gives instruction=0x00000013, fetch_fault=1, fetch_valid=1.
- Fetch 0 then assert fetch_stall for 3 cycles while driving fetch_req at address 4 -> outputs frozen at the address-0 response; after the stall drops, address 4 is returned one cycle after re-request.
- fetch_req during LOAD -> fetch_valid stays 0; load_en at 0x6 -> load_err=1, load_count unchanged.
- load_en at 4 and load_done in the same cycle -> run_mode=1 next cycle and a fetch at 4 returns the loaded word.
- Reset mid-RUN, then load_done with no new loads, then fetch 0 -> returns the pre-reset word; load_count=0.
